// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: op encoding and the overflow rule.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's-complement overflow: operands agree in sign, result sign differs.
  // b_msb is the MSB of the effective (possibly inverted) B operand.
  function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit adder slice with carry-in and carry-out.
module adder_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: one CHUNK-bit slice per stage, carry registered between
// stages, operands skewed in and results deskewed out. Valid/ready on both sides with
// a combinational ready chain so empty stages collapse under backpressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic              init_q;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] adv;
  logic              accept;

  // Held low through reset so in_ready stays 0 until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // Ready chain: a stage advances when empty or when the stage after it advances.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~valid_q[STAGES-1] | out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      adv[k] = ~valid_q[k] | adv[k+1];
    end
  end

  assign in_ready  = init_q & adv[0];
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q[STAGES-1];
  assign busy      = |valid_q;

  // Stage valid bits move forward only where the stage advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (adv[0]) valid_q[0] <= accept;
      for (int k = 1; k < int'(STAGES); k++) begin
        if (adv[k]) valid_q[k] <= valid_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed on entry to this stage, and result bits done after it.
    localparam int unsigned Rem  = WIDTH - k * CHUNK;
    localparam int unsigned Done = (k + 1) * CHUNK;

    logic [Rem-1:0]   a_src;
    logic [Rem-1:0]   b_src;
    logic             c_src;
    logic             ld;
    logic [CHUNK-1:0] s_slice;
    logic             c_slice;
    logic [Done-1:0]  sum_d;
    logic [Done-1:0]  sum_q;
    logic             c_q;

    if (k == 0) begin : g_head
      // SUB is folded in here: invert B and the borrow so later stages only add.
      assign a_src = in_a;
      assign b_src = (in_op == OP_SUB) ? ~in_b : in_b;
      assign c_src = (in_op == OP_SUB) ? ~in_cin : in_cin;
      assign ld    = accept;
      assign sum_d = s_slice;
    end else begin : g_body
      assign a_src = g_stage[k-1].g_fwd.a_q;
      assign b_src = g_stage[k-1].g_fwd.b_q;
      assign c_src = g_stage[k-1].c_q;
      assign ld    = adv[k] & valid_q[k-1];
      assign sum_d = {s_slice, g_stage[k-1].sum_q};
    end

    adder_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a_i    (a_src[CHUNK-1:0]),
      .b_i    (b_src[CHUNK-1:0]),
      .cin_i  (c_slice_cin(c_src)),
      .sum_o  (s_slice),
      .cout_o (c_slice)
    );

    // Completed low result bits and the carry into the next slice.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (ld) begin
        sum_q <= sum_d;
        c_q   <= c_slice;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [Rem-CHUNK-1:0] a_q;
      logic [Rem-CHUNK-1:0] b_q;

      // Carry the unprocessed upper operand slices along with the entry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld) begin
          a_q <= a_src[Rem-1:CHUNK];
          b_q <= b_src[Rem-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Overflow needs the operand MSBs, which are only present in the final slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (ld) begin
          ovf_q <= ovf_flag(a_src[Rem-1], b_src[Rem-1], s_slice[CHUNK-1]);
        end
      end
    end
  end

  assign out_sum  = g_stage[STAGES-1].sum_q;
  assign out_cout = g_stage[STAGES-1].c_q;
  assign out_ovf  = g_stage[STAGES-1].g_tail.ovf_q;

  function automatic logic c_slice_cin(input logic c);
    return c;
  endfunction

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: a 32/8 instance (4 stages) and a 4/4 instance (1 stage).
module tb_pipelined_adder;

  localparam int unsigned LAT32 = 3;  // edges after the accepting edge until out_valid

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_cin, in_op, out_valid, out_ready, out_cout, out_ovf, busy;
  logic [31:0] in_a, in_b, out_sum;
  logic        n_in_valid, n_in_ready, n_in_cin, n_in_op, n_out_valid, n_out_ready;
  logic        n_out_cout, n_out_ovf, n_busy;
  logic [3:0]  n_in_a, n_in_b, n_out_sum;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        op;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t sb[$];
  exp_t nq[$];

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_cin(in_cin), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy)
  );

  pipelined_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_a(n_in_a),
    .in_b(n_in_b), .in_cin(n_in_cin), .in_op(n_in_op), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .out_sum(n_out_sum), .out_cout(n_out_cout),
    .out_ovf(n_out_ovf), .busy(n_busy)
  );

  // Full-width reference for a w-bit add/sub.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic op, input int w);
    exp_t        m;
    logic [31:0] mask, am, be;
    logic        ce;
    logic [32:0] r;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am     = a & mask;
    be     = (op ? ~b : b) & mask;
    ce     = op ? ~cin : cin;
    r      = {1'b0, am} + {1'b0, be} + {32'd0, ce};
    m.sum  = r[31:0] & mask;
    m.cout = r[w];
    m.ovf  = (am[w-1] == be[w-1]) && (r[w-1] != am[w-1]);
    return m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_op = 1'b0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_a = '0; n_in_b = '0; n_in_cin = 1'b0; n_in_op = 1'b0;
    n_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({out_sum, out_cout, out_ovf} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs: got %h/%b/%b want 0/0/0", out_sum, out_cout, out_ovf);
    end
    checks++; if (n_in_ready !== 1'b0) begin errors++; $display("FAIL reset_n_in_ready: got %b want 0", n_in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_no_edge_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_edge_in_ready: got %b want 1", in_ready); end
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL post_edge_n_in_ready: got %b want 1", n_in_ready); end
  endtask

  // Send one 32-bit transaction, expect it after LAT32 further edges.
  task automatic single32(input vec_t t, input string name);
    exp_t e;
    int   lat;
    @(negedge clk);
    in_valid = 1'b1; in_a = t.a; in_b = t.b; in_cin = t.cin; in_op = t.op; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
    sb.push_back('{sum: t.sum, cout: t.cout, ovf: t.ovf});
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_op = 1'($urandom);
    #1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    checks++; if (lat != int'(LAT32)) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT32); end
    if (out_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL %s_result: got %h/%b/%b want %h/%b/%b", name, out_sum, out_cout, out_ovf,
                 e.sum, e.cout, e.ovf);
      end
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: got %b want 0", name, out_valid); end
  endtask

  task automatic test_directed();
    vec_t t[6];
    t[0] = '{a: 32'hFFFF_FFFF, b: 32'h1, cin: 1'b0, op: 1'b0, sum: 32'h0, cout: 1'b1, ovf: 1'b0};
    t[1] = '{a: 32'h7FFF_FFFF, b: 32'h1, cin: 1'b0, op: 1'b0, sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1};
    t[2] = '{a: 32'h8000_0000, b: 32'h8000_0000, cin: 1'b0, op: 1'b0, sum: 32'h0, cout: 1'b1, ovf: 1'b1};
    t[3] = '{a: 32'd5, b: 32'd7, cin: 1'b0, op: 1'b1, sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0};
    t[4] = '{a: 32'h8000_0000, b: 32'd1, cin: 1'b0, op: 1'b1, sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1};
    t[5] = '{a: 32'd10, b: 32'd3, cin: 1'b1, op: 1'b1, sum: 32'd6, cout: 1'b1, ovf: 1'b0};
    sb.delete();
    foreach (t[i]) single32(t[i], $sformatf("dir%0d", i));
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   sent = 0, recv = 0, cyc = 0, stall_left = 3;
    bit   stall_done = 0, saw_full = 0, exp_rdy;
    sb.delete();
    while (recv < 10 && cyc < 200) begin
      @(negedge clk);
      if (recv >= 3 && !stall_done) begin
        out_ready = 1'b0;
        stall_left--;
        if (stall_left == 0) stall_done = 1;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (sent < 10);
      in_a     = (sent < 10) ? 32'(sent) : $urandom;
      in_b     = 32'(sent) * 32'h100;
      in_cin   = 1'b0;
      in_op    = 1'b0;
      #1;
      exp_rdy = (sb.size() < 4) || out_ready;
      checks++; if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (sb.size() == 4 && !out_ready && in_ready === 1'b0) saw_full = 1;
      if (recv > 0) begin
        checks++; if (out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_throughput cyc%0d: out_valid got %b want 1", cyc, out_valid);
        end
      end
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_spurious cyc%0d: got out_valid 1 want 0", cyc);
        end else begin
          e = sb[0];
          checks++;
          if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("FAIL b2b_result%0d cyc%0d: got %h/%b/%b want %h/%b/%b", recv, cyc, out_sum,
                     out_cout, out_ovf, e.sum, e.cout, e.ovf);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            recv++;
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        sb.push_back(model(in_a, in_b, in_cin, in_op, 32));
        sent++;
      end
      cyc++;
    end
    checks++; if (recv != 10) begin errors++; $display("FAIL b2b_count: got %0d want 10", recv); end
    checks++; if (!saw_full) begin errors++; $display("FAIL b2b_full_block: got in_ready never 0 at 4 entries want 0"); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    vec_t t;
    sb.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'(i + 1); in_b = 32'(i + 100); in_cin = 1'b0; in_op = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_async_in_ready: got %b want 0", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_spurious%0d: got valid %b busy %b want 0 0", i, out_valid, busy);
      end
    end
    t = '{a: 32'd3, b: 32'd4, cin: 1'b0, op: 1'b0, sum: 32'd7, cout: 1'b0, ovf: 1'b0};
    single32(t, "post_reset");
  endtask

  task automatic test_narrow();
    exp_t e;
    int   sent = 0, recv = 0, cyc = 0;
    nq.delete();
    @(negedge clk);
    n_in_valid = 1'b1; n_in_a = 4'hA; n_in_b = 4'h7; n_in_cin = 1'b1; n_in_op = 1'b0;
    n_out_ready = 1'b1;
    #1;
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL n_dir_in_ready: got %b want 1", n_in_ready); end
    @(negedge clk);
    n_in_valid = 1'b0;
    #1;
    checks++; if (n_out_valid !== 1'b1) begin errors++; $display("FAIL n_dir_latency: got %b want 1", n_out_valid); end
    checks++; if ({n_out_sum, n_out_cout, n_out_ovf} !== {4'h2, 1'b1, 1'b0}) begin
      errors++; $display("FAIL n_dir_result: got %h/%b/%b want 2/1/0", n_out_sum, n_out_cout, n_out_ovf);
    end
    @(negedge clk); #1;
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("FAIL n_dir_drain: got %b want 0", n_out_valid); end
    while (recv < 12 && cyc < 100) begin
      @(negedge clk);
      n_out_ready = 1'b1;
      n_in_valid  = (sent < 12);
      n_in_a      = 4'($urandom);
      n_in_b      = 4'($urandom);
      n_in_cin    = 1'($urandom);
      n_in_op     = 1'($urandom);
      #1;
      checks++; if (n_in_ready !== 1'b1) begin
        errors++; $display("FAIL n_b2b_in_ready cyc%0d: got %b want 1", cyc, n_in_ready);
      end
      checks++; if (n_out_valid !== (nq.size() != 0)) begin
        errors++; $display("FAIL n_b2b_out_valid cyc%0d: got %b want %b", cyc, n_out_valid, nq.size() != 0);
      end
      if (n_out_valid === 1'b1 && nq.size() > 0) begin
        e = nq.pop_front();
        recv++;
        checks++;
        if ({n_out_sum, n_out_cout, n_out_ovf} !== {e.sum[3:0], e.cout, e.ovf}) begin
          errors++;
          $display("FAIL n_b2b_result cyc%0d: got %h/%b/%b want %h/%b/%b", cyc, n_out_sum,
                   n_out_cout, n_out_ovf, e.sum[3:0], e.cout, e.ovf);
        end
      end
      if (n_in_valid && n_in_ready === 1'b1) begin
        nq.push_back(model({28'd0, n_in_a}, {28'd0, n_in_b}, n_in_cin, n_in_op, 4));
        sent++;
      end
      cyc++;
    end
    checks++; if (recv != 12) begin errors++; $display("FAIL n_b2b_count: got %0d want 12", recv); end
    @(negedge clk);
    n_in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_narrow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
